// File: rtl/pool_relu_if.sv
// Stream interface for pool_relu: pixel input beat and pooled-pixel output.
interface pool_relu_if #(
    parameter int OC = 15,
    parameter int DW = 8
);
    logic                   in_valid;
    logic [(OC+1)*DW-1:0]   in_data;
    logic                   out_valid;
    logic [(OC+1)*DW-1:0]   out_data;
    logic [4:0]             out_row;
    logic [4:0]             out_col;
    logic                   frame_done;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_row, out_col, frame_done
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_row, out_col, frame_done
    );
endinterface

// File: rtl/pool_relu.sv
// Streaming 2x2/stride-2 max-pool over a W x H map, all channels in parallel.
// Optional ReLU on the pooled result when POOL_RELU_EN is defined.

// One channel: horizontal-max register, half-width line buffer, window max.
module pool_relu_lane #(
    parameter int DW = 8,
    parameter int NB = 7,
    parameter int IW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc,
    input  logic                 row0,
    input  logic                 col0,
    input  logic [IW-1:0]        idx,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] pool
);
    logic signed [DW-1:0] h;
    logic signed [DW-1:0] lb [NB];
    logic signed [DW-1:0] hmax;
    logic signed [DW-1:0] m;

    always_comb begin
        hmax = (din > h) ? din : h;
        m    = (hmax > lb[idx]) ? hmax : lb[idx];
`ifdef POOL_RELU_EN
        pool = m[DW-1] ? '0 : m;
`else
        pool = m;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            h <= '0;
        else if (acc && !col0)
            h <= din;
    end

    // Written in every even row before the odd row reads it, so no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && acc && col0 && !row0)
            lb[idx] <= hmax;
    end
endmodule

module pool_relu #(
    parameter int OC = 15,
    parameter int DW = 8,
    parameter int W  = 14,
    parameter int H  = 14
) (
    input  logic        clk,
    input  logic        rst,
    pool_relu_if.slave  bus
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam int RW = (H > 2) ? $clog2(H) : 1;
    localparam int NB = W / 2;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [IW-1:0]        idx;
    logic [OC:0][DW-1:0]  pool;
    logic                 fire;

    assign idx  = IW'(col >> 1);
    assign fire = bus.in_valid && row[0] && col[0];

    for (genvar c = 0; c <= OC; c++) begin : g_lane
        pool_relu_lane #(.DW(DW), .NB(NB), .IW(IW)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .acc  (bus.in_valid),
            .row0 (row[0]),
            .col0 (col[0]),
            .idx  (idx),
            .din  (bus.in_data[c*DW +: DW]),
            .pool (pool[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row            <= '0;
            col            <= '0;
            bus.out_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.out_data   <= '0;
            bus.out_row    <= '0;
            bus.out_col    <= '0;
        end else begin
            bus.out_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            if (bus.in_valid) begin
                if (col == CW'(W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(H - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (fire) begin
                bus.out_valid  <= 1'b1;
                bus.out_data   <= pool;
                bus.out_row    <= 5'(row >> 1);
                bus.out_col    <= 5'(col >> 1);
                bus.frame_done <= (row == RW'(H - 1)) && (col == CW'(W - 1));
            end
        end
    end
endmodule

// File: tb/tb_pool_relu.sv
// Self-checking bench for pool_relu: full-frame reference model compared every cycle.
module tb_pool_relu;
    localparam int OC   = 15;
    localparam int DW   = 8;
    localparam int W    = 14;
    localparam int H    = 14;
    localparam int DATA = (OC+1)*DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pool_relu_if #(.OC(OC), .DW(DW)) bus();

    pool_relu #(.OC(OC), .DW(DW), .W(W), .H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nvec = 0, nerr = 0, npulse = 0, nfd = 0;
    int mr = 0, mc = 0;
    logic [DATA-1:0] fr  [H][W];
    logic [DATA-1:0] img [H][W];
    logic [DATA-1:0] last_d = '0;
    logic [4:0]      last_r = '0, last_c = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA-1:0] splat(input int v);
        logic [DATA-1:0] d;
        for (int ch = 0; ch <= OC; ch++) d[ch*DW +: DW] = DW'(v);
        return d;
    endfunction

    function automatic logic [DATA-1:0] rnd_pix();
        logic [DATA-1:0] d;
        for (int ch = 0; ch <= OC; ch++) d[ch*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    // Expected pooled pixel: max over the four stored pixels of the window ending at (r,c).
    function automatic logic [DATA-1:0] window_max(input int r, input int c);
        logic [DATA-1:0] e;
        for (int ch = 0; ch <= OC; ch++) begin
            int m = -100000;
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++) begin
                    int s;
                    s = $signed(fr[r-1+dr][c-1+dc][ch*DW +: DW]);
                    if (s > m) m = s;
                end
`ifdef POOL_RELU_EN
            if (m < 0) m = 0;
`endif
            e[ch*DW +: DW] = DW'(m);
        end
        return e;
    endfunction

    // Apply one cycle, then check the registered response one step after the edge.
    task automatic beat(input logic v, input logic [DATA-1:0] d);
        logic exp_v, exp_fd;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk); #1;
        exp_v  = 1'b0;
        exp_fd = 1'b0;
        if (v) begin
            fr[mr][mc] = d;
            if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                exp_v  = 1'b1;
                exp_fd = (mr == H-1) && (mc == W-1);
                last_d = window_max(mr, mc);
                last_r = 5'(mr / 2);
                last_c = 5'(mc / 2);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end
        end
        chk("out_valid", bus.out_valid, exp_v);
        chk("frame_done", bus.frame_done, exp_fd);
        chk("out_data", bus.out_data, last_d);
        if (exp_v) begin
            chk("out_row", bus.out_row, last_r);
            chk("out_col", bus.out_col, last_c);
        end
        if (bus.out_valid) npulse++;
        if (bus.frame_done) nfd++;
    endtask

    // rst is held together with a valid beat to show reset wins.
    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = rnd_pix();
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        mr = 0; mc = 0;
        last_d = '0; last_r = '0; last_c = '0;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_out_data", bus.out_data, last_d);
        chk("rst_out_row", bus.out_row, last_r);
        chk("rst_out_col", bus.out_col, last_c);
    endtask

    task automatic send_frame(input bit gap, input int npix);
        int n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (n < npix) begin
                    beat(1'b1, img[r][c]);
                    n++;
                    if (gap) begin
                        beat(1'b0, rnd_pix());
                        beat(1'b0, rnd_pix());
                    end
                end
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = splat(r*W + c);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = rnd_pix();
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = splat(v);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        do_reset();
        do_reset();

        // Ramp, continuous
        fill_ramp();
        npulse = 0; nfd = 0;
        send_frame(1'b0, H*W);
        chk("ramp_pulses", npulse, (W/2)*(H/2));
        chk("ramp_frame_done", nfd, 1);

        // All-negative with one less-negative sample in window (0,0), channel 3
        fill_const(-5);
        img[0][1][3*DW +: DW] = DW'(-2);
        send_frame(1'b0, H*W);

        // Signed extremes on channel 0 of window (0,0)
        fill_rand();
        img[0][0][DW-1:0] = DW'(-128);
        img[0][1][DW-1:0] = DW'(127);
        img[1][0][DW-1:0] = DW'(0);
        img[1][1][DW-1:0] = DW'(-1);
        send_frame(1'b0, H*W);

        // Gapped ramp: 1,0,0,1,... on in_valid
        fill_ramp();
        npulse = 0; nfd = 0;
        send_frame(1'b1, H*W);
        chk("gap_pulses", npulse, (W/2)*(H/2));
        chk("gap_frame_done", nfd, 1);

        // Reset after 40 accepted pixels, then a clean constant frame
        fill_rand();
        send_frame(1'b0, 40);
        do_reset();
        fill_const(9);
        npulse = 0; nfd = 0;
        send_frame(1'b0, H*W);
        chk("midrst_pulses", npulse, (W/2)*(H/2));
        chk("midrst_frame_done", nfd, 1);
        chk("midrst_last_data", bus.out_data, splat(9));

        // Two random frames back to back
        npulse = 0; nfd = 0;
        fill_rand();
        send_frame(1'b0, H*W);
        fill_rand();
        send_frame(1'b0, H*W);
        chk("b2b_pulses", npulse, 2*(W/2)*(H/2));
        chk("b2b_frame_done", nfd, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
